// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, fetch FSM state encoding and special opcodes.
package cpu_pkg;

    localparam int PC_WIDTH = 16;

    // Opcode in instr[15:12] that stops fetch when halt support is built in
    localparam logic [3:0] OPC_HLT = 4'hF;

    // Value shown on the decode interface before the first delivery
    localparam logic [15:0] INSTR_NOP = 16'h0000;

    // Fetch FSM states; the encoding is visible on the debug port
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT_DS = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALTED  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit adder/subtractor with a signed overflow flag.
// sub_i=1 computes a_i - b_i as a_i + ~b_i + 1.
module addsub_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] sum_o,
    output logic        ovf_o
);

    logic [15:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + {15'd0, sub_i};
    // Overflow when both operands share a sign that the result does not
    assign ovf_o = (a_i[15] == b_eff[15]) && (sum_o[15] != a_i[15]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to instruction
// memory and hands {instr, pc} to decode over valid/ready.
//
// Handshakes:
//   imem: imem_req rises with imem_addr and both hold until a 1-cycle imem_ack;
//         imem_req is always low for at least one cycle after an ack.
//   decode: a transfer happens on a rising edge where if_valid & if_ready;
//           if_instr/if_pc hold while if_valid is high and not accepted.
//   A redirect pulse outranks everything, including a same-cycle transfer.
//
// Optional feature macro: FETCH_HALT_EN (stop fetching after delivering HLT).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]          HALT_OPCODE = OPC_HLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [15:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                halted,
    output logic [1:0]          dbg_state
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                imem_req_q, imem_req_d;
    logic                if_valid_q, if_valid_d;
    logic [15:0]         if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                halted_q, halted_d;

    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_plus2;
    logic                ovf_unused;
    logic                ack_ok;
    logic                xfer;
    logic                rdata_halt;
    logic                held_halt;

    // Branch targets are halfword aligned
    assign target     = {redirect_pc[PC_WIDTH-1:1], 1'b0};
    // An ack only counts while a request is up, so a stray ack after reset is ignored
    assign ack_ok     = imem_ack & imem_req_q;
    assign xfer       = if_valid_q & if_ready;
    assign rdata_halt = HALT_EN && (imem_rdata[15:12] == HALT_OPCODE);
    assign held_halt  = HALT_EN && (if_instr_q[15:12] == HALT_OPCODE);

    addsub_16bit u_pc_inc (
        .a_i   (req_addr_q),
        .b_i   (16'h0002),
        .sub_i (1'b0),
        .sum_o (pc_plus2),
        .ovf_o (ovf_unused)
    );

    // State and datapath registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= INSTR_NOP;
            if_pc_q    <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            imem_req_q <= imem_req_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state selection; redirect takes precedence in every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // An outstanding request must still be drained
                    if (imem_req_q && !ack_ok) state_d = ST_DISCARD;
                end else if (ack_ok) begin
                    state_d = ST_WAIT_DS;
                end
            end
            ST_WAIT_DS: begin
                if (redirect_valid)  state_d = ST_FETCH;
                else if (xfer)       state_d = held_halt ? ST_HALTED : ST_FETCH;
            end
            ST_DISCARD: begin
                if (ack_ok) state_d = ST_FETCH;
            end
            ST_HALTED: begin
                if (redirect_valid) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Next values of the PC, request and decode-side output registers
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        imem_req_d = imem_req_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        halted_d   = halted_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (ack_ok) begin
                        // Data dropped; request line rests one cycle before the target
                        req_addr_d = target;
                        imem_req_d = 1'b0;
                    end else if (!imem_req_q) begin
                        // Nothing in flight yet: simply retarget
                        req_addr_d = target;
                        imem_req_d = 1'b1;
                    end
                end else if (ack_ok) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_addr_q;
                    if_valid_d = 1'b1;
                    imem_req_d = 1'b0;
                    pc_d       = rdata_halt ? req_addr_q : pc_plus2;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_WAIT_DS: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = target;
                    req_addr_d = target;
                    imem_req_d = 1'b1;
                end else if (xfer) begin
                    if_valid_d = 1'b0;
                    if (held_halt) begin
                        halted_d = 1'b1;
                    end else begin
                        req_addr_d = pc_q;
                        imem_req_d = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) pc_d = target;
                if (ack_ok) begin
                    req_addr_d = redirect_valid ? target : pc_q;
                    imem_req_d = 1'b0;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    halted_d   = 1'b0;
                    pc_d       = target;
                    req_addr_d = target;
                    imem_req_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected requests and
// deliveries; a monitor compares them as the DUT presents them.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;
    logic [1:0]  dbg_state;

    logic [15:0] req_q[$];
    logic [31:0] del_q[$];
    int          n_vec;
    int          n_err;
    int          mem_lat;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: HLT at 0010, otherwise opcode 1 with the low address bits
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
    endtask

    // what: 0 = request queue drained, 1 = delivery queue drained, 2 = if_valid high
    task automatic wait_for(input int what, input string tag);
        int budget = 200;
        bit done = 1'b0;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
            case (what)
                0:       done = (req_q.size() == 0);
                1:       done = (del_q.size() == 0);
                default: done = if_valid;
            endcase
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_%s: condition not reached in 200 cycles", tag);
        end
    endtask

    // Called at a negedge; holds the redirect for exactly one rising edge
    task automatic pulse_redirect(input logic [15:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: ack after mem_lat cycles of a raised request
    initial begin : imem_model
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst || imem_ack || !imem_req) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else begin
                cnt++;
                if (cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt        = 0;
                end
            end
        end
    end

    // Monitor: samples just before each rising edge
    initial begin : monitor
        logic        prev_req;
        logic        prev_ack;
        logic [15:0] prev_addr;
        logic [31:0] exp_del;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 16'h0000;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (imem_req) begin
                    if (!prev_req || prev_ack) begin
                        if (req_q.size() == 0) flag("req_unexpected", 32'(imem_addr));
                        else check("req_addr", 32'(imem_addr), 32'(req_q.pop_front()));
                    end else begin
                        check("req_addr_stable", 32'(imem_addr), 32'(prev_addr));
                    end
                end
                if (if_valid && if_ready && !redirect_valid) begin
                    if (del_q.size() == 0) flag("deliver_unexpected", {if_instr, if_pc});
                    else begin
                        exp_del = del_q.pop_front();
                        check("deliver_instr_pc", {if_instr, if_pc}, exp_del);
                    end
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    // Directed stimulus
    initial begin
        n_vec          = 0;
        n_err          = 0;
        mem_lat        = 2;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        if_ready       = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_imem_req",  32'(imem_req),  32'(1'b0));
        check("rst_imem_addr", 32'(imem_addr), 32'(16'h0000));
        check("rst_if_valid",  32'(if_valid),  32'(1'b0));
        check("rst_if_instr",  32'(if_instr),  32'(16'h0000));
        check("rst_if_pc",     32'(if_pc),     32'(16'h0000));
        check("rst_halted",    32'(halted),    32'(1'b0));
        check("rst_state",     32'(dbg_state), 32'(2'd0));

        // Sequential fetch, 2-cycle memory, decode always ready
        req_q.push_back(16'h0000);
        req_q.push_back(16'h0002);
        req_q.push_back(16'h0004);
        del_q.push_back({16'h1000, 16'h0000});
        del_q.push_back({16'h1002, 16'h0002});
        rst = 1'b0;
        wait_for(1, "seq_deliver");

        // Decode stalls: 0004 is held, no new request
        if_ready = 1'b0;
        wait_for(2, "hold_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_if_valid", 32'(if_valid), 32'(1'b1));
            check("hold_if_instr", 32'(if_instr), 32'(16'h1004));
            check("hold_if_pc",    32'(if_pc),    32'(16'h0004));
            check("hold_imem_req", 32'(imem_req), 32'(1'b0));
            @(negedge clk);
        end
        del_q.push_back({16'h1004, 16'h0004});
        req_q.push_back(16'h0006);
        mem_lat  = 4;
        if_ready = 1'b1;

        // Redirect to 0041 while 0006 is outstanding
        wait_for(0, "req_0006");
        req_q.push_back(16'h0040);
        req_q.push_back(16'h0042);
        del_q.push_back({16'h1040, 16'h0040});
        pulse_redirect(16'h0041);

        // Redirect in the same cycle as the ack of 0042
        wait_for(0, "req_0042");
        req_q.push_back(16'h0060);
        repeat (2) @(negedge clk);
        pulse_redirect(16'h0060);
        check("ack_redir_req_drop", 32'(imem_req),  32'(1'b0));
        check("ack_redir_addr",     32'(imem_addr), 32'(16'h0060));

        // Redirect in the same cycle as a decode transfer of 0060
        wait_for(0, "req_0060");
        wait_for(2, "valid_0060");
        req_q.push_back(16'hFFFE);
        req_q.push_back(16'h0000);
        del_q.push_back({16'h1FFE, 16'hFFFE});
        pulse_redirect(16'hFFFF);

        // FFFE delivered, sequential wrap to 0000; then stall decode
        wait_for(1, "deliver_fffe");
        if_ready = 1'b0;
        wait_for(2, "valid_0000");

        // Kill held 0000, fetch HLT at 0010
        req_q.push_back(16'h0010);
        del_q.push_back({16'hF000, 16'h0010});
`ifndef FETCH_HALT_EN
        req_q.push_back(16'h0012);
`endif
        pulse_redirect(16'h0010);
        if_ready = 1'b1;
        wait_for(1, "deliver_hlt");
        if_ready = 1'b0;
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 4; i++) begin
            check("halt_halted",   32'(halted),   32'(1'b1));
            check("halt_imem_req", 32'(imem_req), 32'(1'b0));
            check("halt_if_valid", 32'(if_valid), 32'(1'b0));
            @(negedge clk);
        end
        req_q.push_back(16'h0020);
        pulse_redirect(16'h0020);
        check("unhalt_halted",    32'(halted),    32'(1'b0));
        check("unhalt_imem_req",  32'(imem_req),  32'(1'b1));
        check("unhalt_imem_addr", 32'(imem_addr), 32'(16'h0020));
`else
        check("nohalt_halted", 32'(halted), 32'(1'b0));
`endif
        wait_for(0, "final_req");

        // Nothing left unmatched
        repeat (10) @(negedge clk);
        check("req_q_left", 32'(req_q.size()), 32'd0);
        check("del_q_left", 32'(del_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
